// File: rtl/nes_fetch_sequencer.sv
// 6502-style fetch/control-flow sequencer: reset-vector load, opcode fetch, relative branches,
// JMP abs/ind, NOP and flag ops with cycle-true timing; any other opcode is flagged as illegal.
module nes_fetch_sequencer #(
    parameter int unsigned CLK_DIV      = 12,
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
    parameter bit          ILLEGAL_STOP = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  dataIn,
    input  logic        flag_load,
    input  logic [3:0]  flag_in,
    output logic [15:0] addressOut,
    output logic        rw,
    output logic        sync,
    output logic        illegal,
    output logic        halted,
    output logic [3:0]  flags
);
    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_RST_LO, S_RST_HI, S_FETCH, S_NOP2, S_BR_OFF, S_BR_TAKE,
        S_BR_FIX, S_OP_LO, S_OP_HI, S_IND_LO, S_IND_HI, S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      pc_q, pc_d, ptr_q, ptr_d;
    logic [7:0]       op_q, op_d, lo_q, lo_d, off_q, off_d;
    logic [3:0]       flags_q, flags_d, flags_op_s;
    logic             sync_q, sync_d, illegal_q, illegal_d, halted_q, halted_d;
    logic             tick_s, cond_s, cross_s;
    logic [8:0]       pcl_sum_s;

    // Master-clock divider producing the one-clock CPU tick
    always_comb begin
        tick_s = (div_q == DIV_LAST);
        if (tick_s) begin
            div_d = {DIV_W{1'b0}};
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Branch condition select and low-byte target add with page-cross detection
    always_comb begin
        case (op_q[7:6])
            2'b00:   cond_s = flags_q[3];
            2'b01:   cond_s = flags_q[2];
            2'b10:   cond_s = flags_q[0];
            2'b11:   cond_s = flags_q[1];
            default: cond_s = 1'b0;
        endcase
        pcl_sum_s = {1'b0, pc_q[7:0]} + {1'b0, off_q};
        // A negative offset crosses a page when the 8-bit add does NOT carry
        if (off_q[7]) begin
            cross_s = ~pcl_sum_s[8];
        end else begin
            cross_s = pcl_sum_s[8];
        end
    end

    // Next-state and datapath update, applied only on ticks
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ptr_d      = ptr_q;
        op_d       = op_q;
        lo_d       = lo_q;
        off_d      = off_q;
        flags_d    = flags_q;
        flags_op_s = flags_q;
        sync_d     = sync_q;
        illegal_d  = illegal_q;
        halted_d   = halted_q;
        if (tick_s) begin
            illegal_d = 1'b0;
            case (state_q)
                S_RST_LO: begin
                    lo_d    = dataIn;
                    state_d = S_RST_HI;
                end
                S_RST_HI: begin
                    pc_d    = {dataIn, lo_q};
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    op_d = dataIn;
                    pc_d = pc_q + 16'd1;
                    case (dataIn)
                        8'h10, 8'h30, 8'h50, 8'h70,
                        8'h90, 8'hB0, 8'hD0, 8'hF0: state_d = S_BR_OFF;
                        8'h4C, 8'h6C:               state_d = S_OP_LO;
                        8'hEA:                      state_d = S_NOP2;
                        8'h18: begin
                            flags_op_s[0] = 1'b0;
                            state_d       = S_NOP2;
                        end
                        8'h38: begin
                            flags_op_s[0] = 1'b1;
                            state_d       = S_NOP2;
                        end
                        8'hB8: begin
                            flags_op_s[2] = 1'b0;
                            state_d       = S_NOP2;
                        end
                        default: begin
                            illegal_d = 1'b1;
                            if (ILLEGAL_STOP) begin
                                state_d = S_HALT;
                            end else begin
                                state_d = S_FETCH;
                            end
                        end
                    endcase
                end
                S_NOP2: state_d = S_FETCH;
                S_BR_OFF: begin
                    off_d = dataIn;
                    pc_d  = pc_q + 16'd1;
                    if (cond_s == op_q[5]) begin
                        state_d = S_BR_TAKE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_BR_TAKE: begin
                    pc_d = {pc_q[15:8], pcl_sum_s[7:0]};
                    if (cross_s) begin
                        state_d = S_BR_FIX;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_BR_FIX: begin
                    if (off_q[7]) begin
                        pc_d[15:8] = pc_q[15:8] - 8'd1;
                    end else begin
                        pc_d[15:8] = pc_q[15:8] + 8'd1;
                    end
                    state_d = S_FETCH;
                end
                S_OP_LO: begin
                    lo_d    = dataIn;
                    pc_d    = pc_q + 16'd1;
                    state_d = S_OP_HI;
                end
                S_OP_HI: begin
                    if (op_q == 8'h4C) begin
                        pc_d    = {dataIn, lo_q};
                        state_d = S_FETCH;
                    end else begin
                        ptr_d   = {dataIn, lo_q};
                        state_d = S_IND_LO;
                    end
                end
                S_IND_LO: begin
                    lo_d    = dataIn;
                    state_d = S_IND_HI;
                end
                S_IND_HI: begin
                    pc_d    = {dataIn, lo_q};
                    state_d = S_FETCH;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_HALT;
            endcase
            flags_d  = flag_load ? flag_in : flags_op_s;
            sync_d   = (state_d == S_FETCH);
            halted_d = (state_d == S_HALT);
        end else begin
            illegal_d = illegal_q;
        end
    end

    // Sequencer registers; reset abandons any instruction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q     <= {DIV_W{1'b0}};
            state_q   <= S_RST_LO;
            pc_q      <= 16'h0000;
            ptr_q     <= 16'h0000;
            op_q      <= 8'h00;
            lo_q      <= 8'h00;
            off_q     <= 8'h00;
            flags_q   <= 4'h0;
            sync_q    <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            div_q     <= div_d;
            state_q   <= state_d;
            pc_q      <= pc_d;
            ptr_q     <= ptr_d;
            op_q      <= op_d;
            lo_q      <= lo_d;
            off_q     <= off_d;
            flags_q   <= flags_d;
            sync_q    <= sync_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
        end
    end

    // Bus address by state; the indirect high-byte read wraps within the pointer's page
    always_comb begin
        case (state_q)
            S_RST_LO: addressOut = RESET_VECTOR;
            S_RST_HI: addressOut = RESET_VECTOR + 16'd1;
            S_IND_LO: addressOut = ptr_q;
            S_IND_HI: addressOut = {ptr_q[15:8], ptr_q[7:0] + 8'd1};
            default:  addressOut = pc_q;
        endcase
    end

    assign rw      = 1'b1;
    assign sync    = sync_q;
    assign illegal = illegal_q;
    assign halted  = halted_q;
    assign flags   = flags_q;

endmodule

// File: tb/tb_nes_fetch_sequencer.sv
// Scoreboard bench: expected per-cycle {address, sync, illegal} are queued before each run
// and popped against the DUT every CPU cycle; three instances cover the parameter variants.
module tb_nes_fetch_sequencer;
    logic        clock = 1'b0;
    logic        rst_a, rst_b, rst_c;
    logic        flag_load;
    logic [3:0]  flag_in;
    logic [7:0]  mem [0:65535];

    logic [15:0] addr_a, addr_b, addr_c;
    logic [7:0]  data_a, data_b, data_c;
    logic        rw_a, rw_b, rw_c;
    logic        sync_a, sync_b, sync_c;
    logic        ill_a, ill_b, ill_c;
    logic        halt_a, halt_b, halt_c;
    logic [3:0]  flags_a, flags_b, flags_c;

    logic [17:0] exp_q [$];
    logic [17:0] e;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clock = ~clock;

    assign data_a = mem[addr_a];
    assign data_b = mem[addr_b];
    assign data_c = mem[addr_c];

    nes_fetch_sequencer #(.CLK_DIV(1), .RESET_VECTOR(16'hFFFC), .ILLEGAL_STOP(1'b0)) u_dut (
        .clock(clock), .reset(rst_a), .dataIn(data_a), .flag_load(flag_load), .flag_in(flag_in),
        .addressOut(addr_a), .rw(rw_a), .sync(sync_a), .illegal(ill_a), .halted(halt_a), .flags(flags_a));

    nes_fetch_sequencer #(.CLK_DIV(1), .RESET_VECTOR(16'hFFFC), .ILLEGAL_STOP(1'b1)) u_dut_stop (
        .clock(clock), .reset(rst_b), .dataIn(data_b), .flag_load(flag_load), .flag_in(flag_in),
        .addressOut(addr_b), .rw(rw_b), .sync(sync_b), .illegal(ill_b), .halted(halt_b), .flags(flags_b));

    nes_fetch_sequencer #(.CLK_DIV(12), .RESET_VECTOR(16'hFFFC), .ILLEGAL_STOP(1'b0)) u_dut_div (
        .clock(clock), .reset(rst_c), .dataIn(data_c), .flag_load(flag_load), .flag_in(flag_in),
        .addressOut(addr_c), .rw(rw_c), .sync(sync_c), .illegal(ill_c), .halted(halt_c), .flags(flags_c));

    task automatic push_exp(input logic [15:0] a, input logic s, input logic il);
        exp_q.push_back({a, s, il});
    endtask

    // Loads the reset vector, pulses reset and returns on the negedge right after release
    task automatic start_a(input logic [15:0] vec);
        mem[16'hFFFC] = vec[7:0];
        mem[16'hFFFD] = vec[15:8];
        @(negedge clock);
        rst_a = 1'b1;
        @(negedge clock);
        rst_a = 1'b0;
    endtask

    task automatic test_reset;
        mem[16'h8000] = 8'hEA;
        mem[16'h8001] = 8'hEA;
        push_exp(16'hFFFC, 1'b0, 1'b0);
        push_exp(16'hFFFD, 1'b0, 1'b0);
        push_exp(16'h8000, 1'b1, 1'b0);
        push_exp(16'h8001, 1'b0, 1'b0);
        push_exp(16'h8001, 1'b1, 1'b0);
        start_a(16'h8000);
        for (int k = 0; exp_q.size() > 0; k++) begin
            flag_load = (k == 0);
            flag_in   = 4'hF;
            e = exp_q.pop_front();
            n_checks++;
            if ({addr_a, sync_a, ill_a} !== e) begin
                n_fail++;
                $display("FAIL reset_seq k=%0d: got addr=%h sync=%b ill=%b, want addr=%h sync=%b ill=%b",
                         k, addr_a, sync_a, ill_a, e[17:2], e[1], e[0]);
            end
            @(posedge clock);
            @(negedge clock);
        end
        flag_load = 1'b0;
        n_checks++;
        if (flags_a !== 4'hF) begin
            n_fail++;
            $display("FAIL flag_load_all: got %b want 1111", flags_a);
        end
        // Reset in the middle of a NOP2 must snap straight back to the vector fetch
        rst_a = 1'b1;
        #1;
        n_checks++;
        if ({addr_a, sync_a, ill_a, halt_a, rw_a, flags_a} !== {16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got addr=%h sync=%b ill=%b halt=%b rw=%b flags=%b, want FFFC 0 0 0 1 0000",
                     addr_a, sync_a, ill_a, halt_a, rw_a, flags_a);
        end
    endtask

    task automatic test_beq;
        mem[16'h8000] = 8'hF0;
        mem[16'h8001] = 8'h05;
        for (int pass = 0; pass < 2; pass++) begin
            push_exp(16'hFFFC, 1'b0, 1'b0);
            push_exp(16'hFFFD, 1'b0, 1'b0);
            push_exp(16'h8000, 1'b1, 1'b0);
            push_exp(16'h8001, 1'b0, 1'b0);
            if (pass == 0) begin
                push_exp(16'h8002, 1'b0, 1'b0);
                push_exp(16'h8007, 1'b1, 1'b0);
            end else begin
                push_exp(16'h8002, 1'b1, 1'b0);
            end
            start_a(16'h8000);
            for (int k = 0; exp_q.size() > 0; k++) begin
                flag_load = (k == 0) && (pass == 0);
                flag_in   = 4'b0010;
                e = exp_q.pop_front();
                n_checks++;
                if ({addr_a, sync_a, ill_a} !== e) begin
                    n_fail++;
                    $display("FAIL beq pass=%0d k=%0d: got addr=%h sync=%b ill=%b, want addr=%h sync=%b ill=%b",
                             pass, k, addr_a, sync_a, ill_a, e[17:2], e[1], e[0]);
                end
                @(posedge clock);
                @(negedge clock);
            end
            flag_load = 1'b0;
        end
    endtask

    task automatic test_bne_page_cross;
        mem[16'h80FD] = 8'hD0;
        mem[16'h80FE] = 8'h10;
        mem[16'h8100] = 8'hD0;
        mem[16'h8101] = 8'hFC;
        for (int pass = 0; pass < 2; pass++) begin
            logic [15:0] base;
            base = (pass == 0) ? 16'h80FD : 16'h8100;
            push_exp(16'hFFFC, 1'b0, 1'b0);
            push_exp(16'hFFFD, 1'b0, 1'b0);
            push_exp(base, 1'b1, 1'b0);
            push_exp(base + 16'd1, 1'b0, 1'b0);
            push_exp(base + 16'd2, 1'b0, 1'b0);
            push_exp((pass == 0) ? 16'h800F : 16'h81FE, 1'b0, 1'b0);
            push_exp((pass == 0) ? 16'h810F : 16'h80FE, 1'b1, 1'b0);
            start_a(base);
            for (int k = 0; exp_q.size() > 0; k++) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({addr_a, sync_a, ill_a} !== e) begin
                    n_fail++;
                    $display("FAIL bne_cross pass=%0d k=%0d: got addr=%h sync=%b ill=%b, want addr=%h sync=%b ill=%b",
                             pass, k, addr_a, sync_a, ill_a, e[17:2], e[1], e[0]);
                end
                @(posedge clock);
                @(negedge clock);
            end
        end
    endtask

    task automatic test_jmp_ind;
        mem[16'h8000] = 8'h6C;
        mem[16'h8001] = 8'hFF;
        mem[16'h8002] = 8'h30;
        mem[16'h30FF] = 8'h34;
        mem[16'h3000] = 8'h12;
        mem[16'h3100] = 8'h99;
        push_exp(16'hFFFC, 1'b0, 1'b0);
        push_exp(16'hFFFD, 1'b0, 1'b0);
        push_exp(16'h8000, 1'b1, 1'b0);
        push_exp(16'h8001, 1'b0, 1'b0);
        push_exp(16'h8002, 1'b0, 1'b0);
        push_exp(16'h30FF, 1'b0, 1'b0);
        push_exp(16'h3000, 1'b0, 1'b0);
        push_exp(16'h1234, 1'b1, 1'b0);
        start_a(16'h8000);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({addr_a, sync_a, ill_a} !== e) begin
                n_fail++;
                $display("FAIL jmp_ind k=%0d: got addr=%h sync=%b ill=%b, want addr=%h sync=%b ill=%b",
                         k, addr_a, sync_a, ill_a, e[17:2], e[1], e[0]);
            end
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic test_flags_illegal;
        mem[16'h9000] = 8'h38;
        mem[16'h9001] = 8'hB0;
        mem[16'h9002] = 8'h02;
        mem[16'h9005] = 8'h02;
        mem[16'h9006] = 8'hEA;
        push_exp(16'hFFFC, 1'b0, 1'b0);
        push_exp(16'hFFFD, 1'b0, 1'b0);
        push_exp(16'h9000, 1'b1, 1'b0);
        push_exp(16'h9001, 1'b0, 1'b0);
        push_exp(16'h9001, 1'b1, 1'b0);
        push_exp(16'h9002, 1'b0, 1'b0);
        push_exp(16'h9003, 1'b0, 1'b0);
        push_exp(16'h9005, 1'b1, 1'b0);
        push_exp(16'h9006, 1'b1, 1'b1);
        push_exp(16'h9007, 1'b0, 1'b0);
        start_a(16'h9000);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({addr_a, sync_a, ill_a} !== e) begin
                n_fail++;
                $display("FAIL sec_bcs_illegal k=%0d: got addr=%h sync=%b ill=%b, want addr=%h sync=%b ill=%b",
                         k, addr_a, sync_a, ill_a, e[17:2], e[1], e[0]);
            end
            @(posedge clock);
            @(negedge clock);
        end
        n_checks++;
        if (flags_a !== 4'b0001) begin
            n_fail++;
            $display("FAIL sec_flags: got %b want 0001", flags_a);
        end
    endtask

    task automatic test_flag_priority;
        mem[16'hA000] = 8'h18;
        mem[16'hA001] = 8'hB8;
        mem[16'hA002] = 8'h30;
        mem[16'hA003] = 8'h02;
        mem[16'hA004] = 8'hEA;
        push_exp(16'hFFFC, 1'b0, 1'b0);
        push_exp(16'hFFFD, 1'b0, 1'b0);
        push_exp(16'hA000, 1'b1, 1'b0);
        push_exp(16'hA001, 1'b0, 1'b0);
        push_exp(16'hA001, 1'b1, 1'b0);
        push_exp(16'hA002, 1'b0, 1'b0);
        push_exp(16'hA002, 1'b1, 1'b0);
        push_exp(16'hA003, 1'b0, 1'b0);
        push_exp(16'hA004, 1'b1, 1'b0);
        start_a(16'hA000);
        for (int k = 0; exp_q.size() > 0; k++) begin
            flag_load = (k == 2) || (k == 7);
            flag_in   = (k == 2) ? 4'b0101 : 4'b1000;
            e = exp_q.pop_front();
            n_checks++;
            if ({addr_a, sync_a, ill_a} !== e) begin
                n_fail++;
                $display("FAIL flag_prio k=%0d: got addr=%h sync=%b ill=%b, want addr=%h sync=%b ill=%b",
                         k, addr_a, sync_a, ill_a, e[17:2], e[1], e[0]);
            end
            if (k == 3 || k == 5 || k == 8) begin
                logic [3:0] want;
                want = (k == 3) ? 4'b0101 : ((k == 5) ? 4'b0001 : 4'b1000);
                n_checks++;
                if (flags_a !== want) begin
                    n_fail++;
                    $display("FAIL flag_prio_flags k=%0d: got %b want %b", k, flags_a, want);
                end
            end
            @(posedge clock);
            @(negedge clock);
        end
        flag_load = 1'b0;
        rst_a = 1'b1;
    endtask

    task automatic test_illegal_stop;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'hB0;
        mem[16'hB000] = 8'h02;
        mem[16'hB001] = 8'hEA;
        push_exp(16'hFFFC, 1'b0, 1'b0);
        push_exp(16'hFFFD, 1'b0, 1'b0);
        push_exp(16'hB000, 1'b1, 1'b0);
        push_exp(16'hB001, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) push_exp(16'hB001, 1'b0, 1'b0);
        @(negedge clock);
        rst_b = 1'b0;
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({addr_b, sync_b, ill_b, halt_b} !== {e, (k >= 3)}) begin
                n_fail++;
                $display("FAIL illegal_stop k=%0d: got addr=%h sync=%b ill=%b halt=%b, want addr=%h sync=%b ill=%b halt=%b",
                         k, addr_b, sync_b, ill_b, halt_b, e[17:2], e[1], e[0], (k >= 3));
            end
            @(posedge clock);
            @(negedge clock);
        end
        rst_b = 1'b1;
    endtask

    task automatic test_clk_div;
        mem[16'hFFFC] = 8'hFD;
        mem[16'hFFFD] = 8'h80;
        mem[16'h80FD] = 8'hD0;
        mem[16'h80FE] = 8'h10;
        push_exp(16'hFFFC, 1'b0, 1'b0);
        push_exp(16'hFFFD, 1'b0, 1'b0);
        push_exp(16'h80FD, 1'b1, 1'b0);
        push_exp(16'h80FE, 1'b0, 1'b0);
        push_exp(16'h80FF, 1'b0, 1'b0);
        push_exp(16'h800F, 1'b0, 1'b0);
        @(negedge clock);
        rst_c = 1'b0;
        for (int w = 0; exp_q.size() > 0; w++) begin
            e = exp_q.pop_front();
            for (int j = 0; j < 12; j++) begin
                n_checks++;
                if ({addr_c, sync_c, ill_c} !== e) begin
                    n_fail++;
                    $display("FAIL clk_div w=%0d j=%0d: got addr=%h sync=%b ill=%b, want addr=%h sync=%b ill=%b",
                             w, j, addr_c, sync_c, ill_c, e[17:2], e[1], e[0]);
                end
                if (w == 5 && j == 5) begin
                    rst_c = 1'b1;
                    #1;
                    n_checks++;
                    if ({addr_c, sync_c, halt_c} !== {16'hFFFC, 1'b0, 1'b0}) begin
                        n_fail++;
                        $display("FAIL clk_div_reset: got addr=%h sync=%b halt=%b, want addr=fffc sync=0 halt=0",
                                 addr_c, sync_c, halt_c);
                    end
                    break;
                end
                @(posedge clock);
                @(negedge clock);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        rst_c     = 1'b1;
        flag_load = 1'b0;
        flag_in   = 4'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        test_reset();
        test_beq();
        test_bne_page_cross();
        test_jmp_ind();
        test_flags_illegal();
        test_flag_priority();
        test_illegal_stop();
        test_clk_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
